riscv_core_reorder_buffer: RTL and testbench

RISCV_CORE_REORDER_BUFFER -- requirements
Module: riscv_CoreReorderBuffer

---
 rtl/riscv_core_reorder_buffer.sv | 124 ++++++++++++
 tb/tb_riscv_core_reorder_buffer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/riscv_core_reorder_buffer.sv
// riscv_core_reorder_buffer: 32-entry dual-issue, dual-commit reorder buffer with bypass read ports
module riscv_core_reorder_buffer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        alloc_A_val,
  input  logic        alloc_B_val,
  input  logic        alloc_A_wen,
  input  logic        alloc_B_wen,
  input  logic [4:0]  alloc_A_rd,
  input  logic [4:0]  alloc_B_rd,
  output logic [4:0]  alloc_A_slot,
  output logic [4:0]  alloc_B_slot,
  output logic        alloc_rdy,
  input  logic        fill_A_val,
  input  logic        fill_B_val,
  input  logic [4:0]  fill_A_slot,
  input  logic [4:0]  fill_B_slot,
  input  logic [31:0] fill_A_data,
  input  logic [31:0] fill_B_data,
  output logic        ROB_commit_ready_A,
  output logic        ROB_commit_ready_B,
  output logic [4:0]  ROB_commit_slot_A,
  output logic [4:0]  ROB_commit_slot_B,
  output logic        commit_A_wen,
  output logic        commit_B_wen,
  output logic [4:0]  commit_A_rd,
  output logic [4:0]  commit_B_rd,
  output logic [31:0] commit_A_data,
  output logic [31:0] commit_B_data,
  input  logic [4:0]  byp_slot_0,
  input  logic [4:0]  byp_slot_1,
  input  logic [4:0]  byp_slot_2,
  input  logic [4:0]  byp_slot_3,
  output logic [31:0] byp_data_0,
  output logic [31:0] byp_data_1,
  output logic [31:0] byp_data_2,
  output logic [31:0] byp_data_3,
  output logic [5:0]  rob_count,
  output logic        rob_full,
  output logic        rob_empty
);
  logic [4:0]  head_q, head_d, tail_q, tail_d, head1;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] valid_q, valid_d, pend_q, pend_d, wen_q;
  logic [31:0] data_q [32];
  logic [4:0]  rd_q [32];
  logic        do_a, do_b, fa, fb;
  logic [1:0]  n_alloc, n_commit;
  assign alloc_rdy          = cnt_q <= 6'd30;
  assign do_a               = alloc_rdy & alloc_A_val;
  assign do_b               = alloc_rdy & alloc_B_val;
  assign alloc_A_slot       = tail_q;
  assign alloc_B_slot       = alloc_A_val ? tail_q + 5'd1 : tail_q;
  assign head1              = head_q + 5'd1;
  assign ROB_commit_ready_A = valid_q[head_q] & ~pend_q[head_q];
  assign ROB_commit_ready_B = ROB_commit_ready_A & valid_q[head1] & ~pend_q[head1];
  assign ROB_commit_slot_A  = head_q;
  assign ROB_commit_slot_B  = head1;
  assign commit_A_wen       = wen_q[head_q];
  assign commit_B_wen       = wen_q[head1];
  assign commit_A_rd        = rd_q[head_q];
  assign commit_B_rd        = rd_q[head1];
  assign commit_A_data      = data_q[head_q];
  assign commit_B_data      = data_q[head1];
  assign byp_data_0         = data_q[byp_slot_0];
  assign byp_data_1         = data_q[byp_slot_1];
  assign byp_data_2         = data_q[byp_slot_2];
  assign byp_data_3         = data_q[byp_slot_3];
  assign rob_count          = cnt_q;
  assign rob_full           = cnt_q == 6'd32;
  assign rob_empty          = cnt_q == 6'd0;
  // fills only land on live entries, so late writebacks to flushed slots vanish
  assign fa                 = fill_A_val & valid_q[fill_A_slot];
  assign fb                 = fill_B_val & valid_q[fill_B_slot];
  assign n_alloc            = {1'b0, do_a} + {1'b0, do_b};
  assign n_commit           = {1'b0, ROB_commit_ready_A} + {1'b0, ROB_commit_ready_B};
  always_comb begin
    valid_d = valid_q;
    pend_d  = pend_q;
    if (ROB_commit_ready_A) valid_d[head_q] = 1'b0;
    if (ROB_commit_ready_B) valid_d[head1] = 1'b0;
    if (do_a) begin
      valid_d[alloc_A_slot] = 1'b1;
      pend_d[alloc_A_slot]  = 1'b1;
    end
    if (do_b) begin
      valid_d[alloc_B_slot] = 1'b1;
      pend_d[alloc_B_slot]  = 1'b1;
    end
    if (fa) pend_d[fill_A_slot] = 1'b0;
    if (fb) pend_d[fill_B_slot] = 1'b0;
    head_d = head_q + {3'b0, n_commit};
    tail_d = tail_q + {3'b0, n_alloc};
    cnt_d  = cnt_q + {4'b0, n_alloc} - {4'b0, n_commit};
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      pend_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      pend_q  <= pend_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
    end
  end
  // payload is not reset; B's fill is written last so it wins a same-slot collision
  always_ff @(posedge clk) begin
    if (do_a) begin
      wen_q[alloc_A_slot] <= alloc_A_wen;
      rd_q[alloc_A_slot]  <= alloc_A_rd;
    end
    if (do_b) begin
      wen_q[alloc_B_slot] <= alloc_B_wen;
      rd_q[alloc_B_slot]  <= alloc_B_rd;
    end
    if (fa) data_q[fill_A_slot] <= fill_A_data;
    if (fb) data_q[fill_B_slot] <= fill_B_data;
  end
endmodule

// File: tb/tb_riscv_core_reorder_buffer.sv
// tb_riscv_core_reorder_buffer: directed scenario tests for the reorder buffer
module tb_riscv_core_reorder_buffer;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        alloc_A_val, alloc_B_val, alloc_A_wen, alloc_B_wen;
  logic [4:0]  alloc_A_rd, alloc_B_rd, alloc_A_slot, alloc_B_slot;
  logic        alloc_rdy;
  logic        fill_A_val, fill_B_val;
  logic [4:0]  fill_A_slot, fill_B_slot;
  logic [31:0] fill_A_data, fill_B_data;
  logic        ROB_commit_ready_A, ROB_commit_ready_B;
  logic [4:0]  ROB_commit_slot_A, ROB_commit_slot_B;
  logic        commit_A_wen, commit_B_wen;
  logic [4:0]  commit_A_rd, commit_B_rd;
  logic [31:0] commit_A_data, commit_B_data;
  logic [4:0]  byp_slot_0, byp_slot_1, byp_slot_2, byp_slot_3;
  logic [31:0] byp_data_0, byp_data_1, byp_data_2, byp_data_3;
  logic [5:0]  rob_count;
  logic        rob_full, rob_empty;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  riscv_core_reorder_buffer dut (
    .clk(clk), .reset_n(reset_n),
    .alloc_A_val(alloc_A_val), .alloc_B_val(alloc_B_val),
    .alloc_A_wen(alloc_A_wen), .alloc_B_wen(alloc_B_wen),
    .alloc_A_rd(alloc_A_rd), .alloc_B_rd(alloc_B_rd),
    .alloc_A_slot(alloc_A_slot), .alloc_B_slot(alloc_B_slot),
    .alloc_rdy(alloc_rdy),
    .fill_A_val(fill_A_val), .fill_B_val(fill_B_val),
    .fill_A_slot(fill_A_slot), .fill_B_slot(fill_B_slot),
    .fill_A_data(fill_A_data), .fill_B_data(fill_B_data),
    .ROB_commit_ready_A(ROB_commit_ready_A), .ROB_commit_ready_B(ROB_commit_ready_B),
    .ROB_commit_slot_A(ROB_commit_slot_A), .ROB_commit_slot_B(ROB_commit_slot_B),
    .commit_A_wen(commit_A_wen), .commit_B_wen(commit_B_wen),
    .commit_A_rd(commit_A_rd), .commit_B_rd(commit_B_rd),
    .commit_A_data(commit_A_data), .commit_B_data(commit_B_data),
    .byp_slot_0(byp_slot_0), .byp_slot_1(byp_slot_1),
    .byp_slot_2(byp_slot_2), .byp_slot_3(byp_slot_3),
    .byp_data_0(byp_data_0), .byp_data_1(byp_data_1),
    .byp_data_2(byp_data_2), .byp_data_3(byp_data_3),
    .rob_count(rob_count), .rob_full(rob_full), .rob_empty(rob_empty)
  );
  task automatic idle();
    alloc_A_val = 0; alloc_B_val = 0; alloc_A_wen = 0; alloc_B_wen = 0;
    alloc_A_rd = 0; alloc_B_rd = 0;
    fill_A_val = 0; fill_B_val = 0; fill_A_slot = 0; fill_B_slot = 0;
    fill_A_data = 0; fill_B_data = 0;
  endtask
  task automatic cyc();
    @(posedge clk); #1;
  endtask
  task automatic alloc2(input logic [4:0] ra, input logic [4:0] rb);
    alloc_A_val = 1; alloc_A_wen = 1; alloc_A_rd = ra;
    alloc_B_val = 1; alloc_B_wen = 1; alloc_B_rd = rb;
    cyc(); idle();
  endtask
  task automatic fill1(input logic [4:0] s, input logic [31:0] d);
    fill_A_val = 1; fill_A_slot = s; fill_A_data = d;
    cyc(); idle();
  endtask
  task automatic pulse_reset();
    reset_n = 0; cyc(); reset_n = 1;
  endtask
  task automatic test_reset();
    reset_n = 0; idle();
    byp_slot_0 = 0; byp_slot_1 = 0; byp_slot_2 = 0; byp_slot_3 = 0;
    #3;
    tests++; if (alloc_rdy !== 1'b1) begin fails++; $display("FAIL rst_rdy got %0b exp 1", alloc_rdy); end
    tests++; if (alloc_A_slot !== 5'd0 || alloc_B_slot !== 5'd0) begin fails++; $display("FAIL rst_slots got %0d/%0d exp 0/0", alloc_A_slot, alloc_B_slot); end
    tests++; if (ROB_commit_ready_A !== 1'b0 || ROB_commit_ready_B !== 1'b0) begin fails++; $display("FAIL rst_ready got %0b%0b exp 00", ROB_commit_ready_A, ROB_commit_ready_B); end
    tests++; if (rob_empty !== 1'b1 || rob_full !== 1'b0 || rob_count !== 6'd0) begin fails++; $display("FAIL rst_occ got e%0b f%0b c%0d exp e1 f0 c0", rob_empty, rob_full, rob_count); end
    cyc(); reset_n = 1;
  endtask
  task automatic test_dual_alloc();
    alloc_A_val = 1; alloc_A_wen = 1; alloc_A_rd = 3;
    alloc_B_val = 1; alloc_B_wen = 1; alloc_B_rd = 4;
    #1;
    tests++; if (alloc_A_slot !== 5'd0 || alloc_B_slot !== 5'd1) begin fails++; $display("FAIL dual_slots got %0d/%0d exp 0/1", alloc_A_slot, alloc_B_slot); end
    cyc(); idle();
    tests++; if (rob_count !== 6'd2) begin fails++; $display("FAIL dual_count got %0d exp 2", rob_count); end
    fill1(5'd1, 32'hBEEF);
    tests++; if (ROB_commit_ready_A !== 1'b0) begin fails++; $display("FAIL dual_ooo_hold got %0b exp 0", ROB_commit_ready_A); end
    fill_A_val = 1; fill_A_slot = 0; fill_A_data = 32'h1234; #1;
    tests++; if (ROB_commit_ready_A !== 1'b0) begin fails++; $display("FAIL dual_fill_latency got %0b exp 0", ROB_commit_ready_A); end
    cyc(); idle();
    byp_slot_0 = 1; byp_slot_1 = 0; #1;
    tests++; if (ROB_commit_ready_A !== 1'b1 || ROB_commit_ready_B !== 1'b1) begin fails++; $display("FAIL dual_ready got %0b%0b exp 11", ROB_commit_ready_A, ROB_commit_ready_B); end
    tests++; if (ROB_commit_slot_A !== 5'd0 || ROB_commit_slot_B !== 5'd1) begin fails++; $display("FAIL dual_cslot got %0d/%0d exp 0/1", ROB_commit_slot_A, ROB_commit_slot_B); end
    tests++; if (commit_A_rd !== 5'd3 || commit_B_rd !== 5'd4 || commit_A_wen !== 1'b1 || commit_B_wen !== 1'b1) begin fails++; $display("FAIL dual_crd got %0d/%0d wen %0b%0b exp 3/4 wen 11", commit_A_rd, commit_B_rd, commit_A_wen, commit_B_wen); end
    tests++; if (commit_A_data !== 32'h1234 || commit_B_data !== 32'hBEEF) begin fails++; $display("FAIL dual_cdata got %h/%h exp 00001234/0000beef", commit_A_data, commit_B_data); end
    tests++; if (byp_data_0 !== 32'hBEEF || byp_data_1 !== 32'h1234) begin fails++; $display("FAIL dual_bypass got %h/%h exp 0000beef/00001234", byp_data_0, byp_data_1); end
    cyc();
    tests++; if (rob_count !== 6'd0 || rob_empty !== 1'b1) begin fails++; $display("FAIL dual_drain got c%0d e%0b exp c0 e1", rob_count, rob_empty); end
  endtask
  task automatic test_out_of_order();
    alloc2(5'd7, 5'd8);
    fill1(5'd3, 32'h33);
    cyc();
    tests++; if (ROB_commit_ready_A !== 1'b0 || rob_count !== 6'd2) begin fails++; $display("FAIL ooo_wait got r%0b c%0d exp r0 c2", ROB_commit_ready_A, rob_count); end
    fill1(5'd2, 32'h22);
    tests++; if (ROB_commit_ready_A !== 1'b1 || ROB_commit_ready_B !== 1'b1 || commit_A_rd !== 5'd7) begin fails++; $display("FAIL ooo_release got %0b%0b rd%0d exp 11 rd7", ROB_commit_ready_A, ROB_commit_ready_B, commit_A_rd); end
    cyc();
    alloc_B_val = 1; alloc_B_rd = 9; #1;
    tests++; if (alloc_B_slot !== 5'd4) begin fails++; $display("FAIL bonly_slot got %0d exp 4", alloc_B_slot); end
    cyc(); idle();
    fill1(5'd4, 32'h44);
    tests++; if (ROB_commit_ready_A !== 1'b1 || ROB_commit_ready_B !== 1'b0 || ROB_commit_slot_A !== 5'd4) begin fails++; $display("FAIL bonly_commit got %0b%0b s%0d exp 10 s4", ROB_commit_ready_A, ROB_commit_ready_B, ROB_commit_slot_A); end
    cyc();
  endtask
  task automatic test_fill_conflict();
    logic [31:0] v9;
    alloc_A_val = 1; alloc_A_wen = 1; alloc_A_rd = 10; cyc(); idle();
    byp_slot_2 = 9; #1; v9 = byp_data_2;
    fill1(5'd9, 32'hDEAD);
    tests++; if (byp_data_2 !== v9 || rob_count !== 6'd1 || ROB_commit_ready_A !== 1'b0) begin fails++; $display("FAIL inval_fill got %h c%0d r%0b exp %h c1 r0", byp_data_2, rob_count, ROB_commit_ready_A, v9); end
    fill_A_val = 1; fill_A_slot = 5; fill_A_data = 32'h1111;
    fill_B_val = 1; fill_B_slot = 5; fill_B_data = 32'h2222;
    cyc(); idle();
    tests++; if (ROB_commit_ready_A !== 1'b1 || commit_A_data !== 32'h2222 || commit_A_rd !== 5'd10) begin fails++; $display("FAIL fill_conflict got r%0b %h rd%0d exp r1 00002222 rd10", ROB_commit_ready_A, commit_A_data, commit_A_rd); end
    cyc();
  endtask
  task automatic test_full_wrap();
    pulse_reset();
    for (int i = 0; i < 15; i++) alloc2(5'(i), 5'(i + 16));
    tests++; if (rob_count !== 6'd30 || alloc_rdy !== 1'b1) begin fails++; $display("FAIL fill30 got c%0d r%0b exp c30 r1", rob_count, alloc_rdy); end
    alloc2(5'd15, 5'd31);
    tests++; if (rob_count !== 6'd32 || alloc_rdy !== 1'b0 || rob_full !== 1'b1 || alloc_A_slot !== 5'd0) begin fails++; $display("FAIL full got c%0d r%0b f%0b t%0d exp c32 r0 f1 t0", rob_count, alloc_rdy, rob_full, alloc_A_slot); end
    alloc2(5'd1, 5'd2);
    tests++; if (rob_count !== 6'd32) begin fails++; $display("FAIL full_block got c%0d exp c32", rob_count); end
    fill1(5'd0, 32'hA0);
    tests++; if (ROB_commit_ready_A !== 1'b1 || ROB_commit_ready_B !== 1'b0 || alloc_rdy !== 1'b0) begin fails++; $display("FAIL full_commit got %0b%0b r%0b exp 10 r0", ROB_commit_ready_A, ROB_commit_ready_B, alloc_rdy); end
    cyc();
    tests++; if (rob_count !== 6'd31 || alloc_rdy !== 1'b0) begin fails++; $display("FAIL full_31 got c%0d r%0b exp c31 r0", rob_count, alloc_rdy); end
    for (int k = 0; k < 15; k++) begin
      fill_A_val = 1; fill_A_slot = 5'(2 * k + 1); fill_A_data = 32'(2 * k + 1);
      fill_B_val = 1; fill_B_slot = 5'(2 * k + 2); fill_B_data = 32'(2 * k + 2);
      cyc();
    end
    idle();
    for (int i = 0; i < 40 && rob_count !== 6'd1; i++) cyc();
    tests++; if (rob_count !== 6'd1 || ROB_commit_slot_A !== 5'd31 || ROB_commit_ready_A !== 1'b0) begin fails++; $display("FAIL drain_to31 got c%0d h%0d r%0b exp c1 h31 r0", rob_count, ROB_commit_slot_A, ROB_commit_ready_A); end
    alloc_A_val = 1; alloc_A_wen = 1; alloc_A_rd = 12; #1;
    tests++; if (alloc_A_slot !== 5'd0) begin fails++; $display("FAIL wrap_alloc got %0d exp 0", alloc_A_slot); end
    cyc(); idle();
    fill_A_val = 1; fill_A_slot = 31; fill_A_data = 32'h31;
    fill_B_val = 1; fill_B_slot = 0; fill_B_data = 32'h100;
    cyc(); idle();
    tests++; if (ROB_commit_ready_A !== 1'b1 || ROB_commit_ready_B !== 1'b1 || ROB_commit_slot_A !== 5'd31 || ROB_commit_slot_B !== 5'd0) begin fails++; $display("FAIL wrap_commit got %0b%0b s%0d/%0d exp 11 s31/0", ROB_commit_ready_A, ROB_commit_ready_B, ROB_commit_slot_A, ROB_commit_slot_B); end
    tests++; if (commit_A_data !== 32'h31 || commit_B_data !== 32'h100 || commit_B_rd !== 5'd12) begin fails++; $display("FAIL wrap_data got %h/%h rd%0d exp 00000031/00000100 rd12", commit_A_data, commit_B_data, commit_B_rd); end
    cyc();
    tests++; if (rob_count !== 6'd0 || ROB_commit_slot_A !== 5'd1 || alloc_A_slot !== 5'd1) begin fails++; $display("FAIL wrap_head got c%0d h%0d t%0d exp c0 h1 t1", rob_count, ROB_commit_slot_A, alloc_A_slot); end
  endtask
  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) alloc2(5'(i + 1), 5'(i + 20));
    fill1(5'd1, 32'h77);
    tests++; if (rob_count !== 6'd10 || ROB_commit_ready_A !== 1'b1) begin fails++; $display("FAIL pre_reset got c%0d r%0b exp c10 r1", rob_count, ROB_commit_ready_A); end
    #2 reset_n = 0; #1;
    tests++; if (alloc_rdy !== 1'b1 || rob_count !== 6'd0 || rob_empty !== 1'b1 || rob_full !== 1'b0) begin fails++; $display("FAIL async_occ got r%0b c%0d e%0b f%0b exp r1 c0 e1 f0", alloc_rdy, rob_count, rob_empty, rob_full); end
    tests++; if (ROB_commit_ready_A !== 1'b0 || ROB_commit_ready_B !== 1'b0 || alloc_A_slot !== 5'd0 || alloc_B_slot !== 5'd0) begin fails++; $display("FAIL async_out got %0b%0b s%0d/%0d exp 00 s0/0", ROB_commit_ready_A, ROB_commit_ready_B, alloc_A_slot, alloc_B_slot); end
    @(negedge clk); reset_n = 1;
    alloc_A_val = 1; alloc_A_wen = 1; alloc_A_rd = 5; #1;
    tests++; if (alloc_A_slot !== 5'd0) begin fails++; $display("FAIL post_reset_slot got %0d exp 0", alloc_A_slot); end
    cyc(); idle();
    tests++; if (rob_count !== 6'd1) begin fails++; $display("FAIL post_reset_count got %0d exp 1", rob_count); end
  endtask
  initial begin
    test_reset();
    test_dual_alloc();
    test_out_of_order();
    test_fill_conflict();
    test_full_wrap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
